// File: rtl/dvi_pkg.sv
// dvi_pkg: TMDS control codes, disparity width and popcount helper
package dvi_pkg;
    localparam int DISP_W = 5;
    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;
    function automatic logic [3:0] popcount(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction
endpackage

// File: rtl/dvi_encoder_tmds_channel.sv
// tmds_channel: two-stage TMDS 8b/10b encoder with running-disparity balancing
module tmds_channel
    import dvi_pkg::*;
(
    input  logic       PCK,
    input  logic       RST,
    input  logic [7:0] D,
    input  logic       DE,
    input  logic [1:0] C,
    output logic [9:0] Q
);
    logic [3:0] n1;
    logic xnor_sel;
    logic [8:0] qm_d, qm_q;
    logic de_q;
    logic [1:0] c_q;
    logic [9:0] q_d, q_q;
    logic signed [DISP_W-1:0] cnt_d, cnt_q, bal;
    logic cnt_pos, cnt_neg, bal_pos, bal_neg;

    // Stage 1: build the transition-minimised 9-bit word
    always_comb begin
        n1 = popcount(D);
        xnor_sel = (n1 > 4'd4) || (n1 == 4'd4 && !D[0]);
        qm_d[0] = D[0];
        for (int i = 1; i < 8; i++) qm_d[i] = xnor_sel ? ~(qm_d[i-1] ^ D[i]) : (qm_d[i-1] ^ D[i]);
        qm_d[8] = ~xnor_sel;
    end

    // Stage 1 register: q_m with DE and control delayed alongside
    always_ff @(posedge PCK) begin
        if (RST) begin
            qm_q <= '0;
            de_q <= 1'b0;
            c_q  <= 2'b00;
        end else begin
            qm_q <= qm_d;
            de_q <= DE;
            c_q  <= C;
        end
    end

    // Stage 2: choose inversion from running disparity, or emit a control code in blanking
    always_comb begin
        bal = $signed({popcount(qm_q[7:0]), 1'b0}) - 5'sd8;
        cnt_pos = !cnt_q[DISP_W-1] && (cnt_q != '0);
        cnt_neg = cnt_q[DISP_W-1];
        bal_pos = !bal[DISP_W-1] && (bal != '0);
        bal_neg = bal[DISP_W-1];
        q_d = CTRL_00;
        cnt_d = '0;
        if (!de_q) begin
            q_d = c_q == 2'b00 ? CTRL_00 : c_q == 2'b01 ? CTRL_01 : c_q == 2'b10 ? CTRL_10 : CTRL_11;
        end else if (cnt_q == '0 || bal == '0) begin
            q_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d = qm_q[8] ? cnt_q + bal : cnt_q - bal;
        end else if ((cnt_pos && bal_pos) || (cnt_neg && bal_neg)) begin
            q_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d = cnt_q - bal + $signed({3'b000, qm_q[8], 1'b0});
        end else begin
            q_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d = cnt_q + bal - $signed({3'b000, ~qm_q[8], 1'b0});
        end
    end

    // Stage 2 register: output character and running disparity
    always_ff @(posedge PCK) begin
        if (RST) begin
            q_q   <= CTRL_00;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign Q = q_q;
endmodule

// File: rtl/dvi_encoder.sv
// dvi_encoder: three TMDS channels for DVI; DVI_SYNC_INVERT_EN inverts HS/VS before CH0 control
module dvi_encoder (
    input  logic       PCK,
    input  logic       RST,
    input  logic [7:0] VGA_R,
    input  logic [7:0] VGA_G,
    input  logic [7:0] VGA_B,
    input  logic       VGA_HS,
    input  logic       VGA_VS,
    input  logic       VGA_DE,
    output logic [9:0] TMDS_CH0,
    output logic [9:0] TMDS_CH1,
    output logic [9:0] TMDS_CH2
);
    logic [1:0] sync;
`ifdef DVI_SYNC_INVERT_EN
    assign sync = ~{VGA_VS, VGA_HS};
`else
    assign sync = {VGA_VS, VGA_HS};
`endif
    tmds_channel u_ch0 (.PCK(PCK), .RST(RST), .D(VGA_B), .DE(VGA_DE), .C(sync), .Q(TMDS_CH0));
    tmds_channel u_ch1 (.PCK(PCK), .RST(RST), .D(VGA_G), .DE(VGA_DE), .C(2'b00), .Q(TMDS_CH1));
    tmds_channel u_ch2 (.PCK(PCK), .RST(RST), .D(VGA_R), .DE(VGA_DE), .C(2'b00), .Q(TMDS_CH2));
endmodule

// File: tb/tb_dvi_encoder.sv
// tb_dvi_encoder: directed vector table plus reference-model run for dvi_encoder
module tb_dvi_encoder;
    logic PCK = 1'b0, RST = 1'b1;
    logic [7:0] VGA_R = '0, VGA_G = '0, VGA_B = '0;
    logic VGA_HS = 1'b0, VGA_VS = 1'b0, VGA_DE = 1'b0;
    logic [9:0] TMDS_CH0, TMDS_CH1, TMDS_CH2;
    int nchk = 0, nerr = 0;
    int cnt_m [3];
`ifdef DVI_SYNC_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    dvi_encoder dut (.PCK(PCK), .RST(RST), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
                     .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
                     .TMDS_CH0(TMDS_CH0), .TMDS_CH1(TMDS_CH1), .TMDS_CH2(TMDS_CH2));

    always #5 PCK = ~PCK;

    typedef struct {
        logic de, hs, vs;
        logic [7:0] d;
        logic [9:0] e0, e12;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        VGA_DE = de; VGA_HS = hs; VGA_VS = vs; VGA_R = r; VGA_G = g; VGA_B = b;
    endtask

    task automatic step;
        @(posedge PCK);
        @(negedge PCK);
    endtask

    function automatic logic [9:0] ctl(input logic [1:0] c);
        case (c)
            2'b00: return 10'h354;
            2'b01: return 10'h0AB;
            2'b10: return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic logic [9:0] enc(input int ch, input logic [7:0] d, input logic de, input logic [1:0] c);
        logic [8:0] qm;
        logic [9:0] r;
        int n1, ones, diff;
        bit xn;
        if (!de) begin
            cnt_m[ch] = 0;
            return ctl(c);
        end
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += d[i] ? 1 : 0;
        xn = n1 > 4 || (n1 == 4 && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += qm[i] ? 1 : 0;
        diff = ones - (8 - ones);
        if (cnt_m[ch] == 0 || diff == 0) begin
            r = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_m[ch] += qm[8] ? diff : -diff;
        end else if ((cnt_m[ch] > 0 && diff > 0) || (cnt_m[ch] < 0 && diff < 0)) begin
            r = {1'b1, qm[8], ~qm[7:0]};
            cnt_m[ch] += (qm[8] ? 2 : 0) - diff;
        end else begin
            r = {1'b0, qm[8], qm[7:0]};
            cnt_m[ch] += diff - (qm[8] ? 0 : 2);
        end
        return r;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] w);
        logic [7:0] x, o;
        x = w[9] ? ~w[7:0] : w[7:0];
        o[0] = x[0];
        for (int i = 1; i < 8; i++) o[i] = w[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
        return o;
    endfunction

    initial begin
        logic pde, de;
        logic [7:0] pb, r, g, b;
        logic [9:0] pe0, pe1, pe2, ce0, ce1, ce2;
        logic [1:0] c0;
        int run;
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 10'h354, 10'h354};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 10'h0AB, 10'h354};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 10'h154, 10'h354};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 10'h2AB, 10'h354};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h00, 10'h100, 10'h100};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h00, 10'h3FF, 10'h3FF};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h00, 10'h100, 10'h100};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 10'h0AB, 10'h354};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h100, 10'h100};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 10'h0FF, 10'h0FF};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h55, 10'h133, 10'h133};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h01, 10'h1FF, 10'h1FF};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h01, 10'h300, 10'h300};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 8'h10, 10'h1F0, 10'h1F0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 8'hF0, 10'h205, 10'h205};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 8'hF0, 10'h0FA, 10'h0FA};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h77, 10'h354, 10'h354};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 10'h354, 10'h354};
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            step();
            chk("reset_ch0", TMDS_CH0, 10'h354);
            chk("reset_ch1", TMDS_CH1, 10'h354);
            chk("reset_ch2", TMDS_CH2, 10'h354);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        RST = 1'b0;
        step();
        step();
        chk("idle_ch0", TMDS_CH0, ctl({INV, INV}));
        chk("idle_ch1", TMDS_CH1, 10'h354);
        for (int i = 0; i <= 18; i++) begin
            if (i < 18) drive(tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].d, tbl[i].d, tbl[i].d);
            step();
            if (i >= 1) begin
                ce0 = tbl[i-1].e0;
                if (!tbl[i-1].de && INV) ce0 = ctl(~{tbl[i-1].vs, tbl[i-1].hs});
                chk($sformatf("tbl%0d_ch0", i-1), TMDS_CH0, ce0);
                chk($sformatf("tbl%0d_ch1", i-1), TMDS_CH1, tbl[i-1].e12);
                chk($sformatf("tbl%0d_ch2", i-1), TMDS_CH2, tbl[i-1].e12);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (3) step();
        RST = 1'b1;
        step();
        chk("midrst_ch0", TMDS_CH0, 10'h354);
        chk("midrst_ch2", TMDS_CH2, 10'h354);
        RST = 1'b0;
        step();
        chk("postrst_flush", TMDS_CH0, 10'h354);
        step();
        chk("postrst_first", TMDS_CH0, 10'h100);
        step();
        chk("postrst_second", TMDS_CH0, 10'h3FF);
        RST = 1'b1;
        step();
        RST = 1'b0;
        cnt_m = '{0, 0, 0};
        de = 1'b0;
        run = 0;
        pde = 1'b0; pb = '0; pe0 = '0; pe1 = '0; pe2 = '0;
        for (int j = 0; j <= 3000; j++) begin
            if (j < 3000) begin
                if (run == 0) begin
                    de = ~de;
                    run = $urandom_range(1, 40);
                end
                run--;
                r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
                c0 = 2'($urandom);
                drive(de, c0[0], c0[1], r, g, b);
                ce0 = enc(0, b, de, c0 ^ {INV, INV});
                ce1 = enc(1, g, de, 2'b00);
                ce2 = enc(2, r, de, 2'b00);
                if (cnt_m[0] > 10 || cnt_m[0] < -10) begin
                    nchk++; nerr++;
                    $display("FAIL model_cnt: got %0d want within 10", cnt_m[0]);
                end
            end
            step();
            if (j >= 1) begin
                if (TMDS_CH0 !== pe0 || TMDS_CH1 !== pe1 || TMDS_CH2 !== pe2) begin
                    nerr++;
                    $display("FAIL rand%0d: got %h %h %h want %h %h %h", j-1, TMDS_CH0, TMDS_CH1, TMDS_CH2, pe0, pe1, pe2);
                end
                nchk++;
                if (pde) chk($sformatf("decode%0d", j-1), {2'b00, dec(TMDS_CH0)}, {2'b00, pb});
            end
            pde = de; pb = b; pe0 = ce0; pe1 = ce1; pe2 = ce2;
        end
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
